// File: rtl/mul_seq_unit.sv
// Sequential shift-and-add multiplier with integrated controller.
// Produces a full 2*WIDTH product, signed or unsigned, with a start/busy/done handshake.
module mul_seq_unit #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 zero_op
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_zero_op;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH-1:0]     w_b_shift;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_result;

    // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned WIDTH bits.
    assign w_a_mag   = (signed_mode && a_in[WIDTH-1]) ? (~a_in + WIDTH'(1)) : a_in;
    assign w_b_mag   = (signed_mode && b_in[WIDTH-1]) ? (~b_in + WIDTH'(1)) : b_in;
    assign w_b_shift = r_b >> 1;
    assign w_last    = (r_cnt == CNT_W'(1)) || (EARLY_EXIT && (w_b_shift == '0));
    assign w_result  = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
            r_zero_op <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= {{WIDTH{1'b0}}, w_a_mag};
                        r_b   <= w_b_mag;
                        r_acc <= '0;
                        r_cnt <= CNT_W'(WIDTH);
                        r_neg <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                    end
                end
                S_CALC: begin
                    if (r_b[0]) r_acc <= r_acc + r_a;
                    r_a   <= r_a << 1;
                    r_b   <= w_b_shift;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIN: begin
                    r_product <= w_result;
                    r_zero_op <= (w_result == '0);
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;
    assign zero_op = r_zero_op;

endmodule
